iter_downcounter: RTL and testbench

//  Loadable down-counter with start/busy/done handshake. It is the counterpart to the modulo up-counter.
//  It sequences a run of `len` enabled steps, for example the shift-add iterations of the signed

---
 rtl/iter_downcounter.sv | 88 ++++++++
 tb/tb_iter_downcounter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iter_downcounter.sv
// Loadable down-counter sequencing a run of len enabled steps with a start/busy/done handshake.
// All outputs are decoded from registered state; a new run may start in the done cycle.
module iter_downcounter #(
   parameter int unsigned W       = 4,
   parameter int unsigned DEF_LEN = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] len,
   input  logic         en,
   input  logic         abort,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         last,
   output logic         done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // DEF_LEN may equal 2^W, so the subtraction is done before truncating to W bits.
   localparam logic [W-1:0] DEF_LOAD = W'(DEF_LEN - 1);

   logic [1:0]   state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] load_val;
   logic         count_zero;

   assign load_val   = (len == '0) ? DEF_LOAD : (len - W'(1));
   assign count_zero = (count_q == '0);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (start) begin
               state_d = RUN;
               count_d = load_val;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (en) begin
               if (count_zero) begin
                  state_d = DONE;
               end else begin
                  count_d = count_q - W'(1);
               end
            end
         end
         DONE: begin
            count_d = '0;
            if (start) begin
               state_d = RUN;
               count_d = load_val;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign last  = (state_q == RUN) && count_zero;
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_iter_downcounter.sv
// Directed bench for iter_downcounter: a vector table of cycle-by-cycle stimulus and expected
// outputs, plus hand-written async-reset and DEF_LEN=2^W sequences.
module tb_iter_downcounter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, en, abort;
   logic [3:0] len;
   logic [3:0] count;
   logic       busy, last, done;

   logic       start16, en16, abort16;
   logic [3:0] len16;
   logic [3:0] count16;
   logic       busy16, last16, done16;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iter_downcounter #(.W(4), .DEF_LEN(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len   (len),
      .en    (en),
      .abort (abort),
      .count (count),
      .busy  (busy),
      .last  (last),
      .done  (done)
   );

   iter_downcounter #(.W(4), .DEF_LEN(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .start (start16),
      .len   (len16),
      .en    (en16),
      .abort (abort16),
      .count (count16),
      .busy  (busy16),
      .last  (last16),
      .done  (done16)
   );

   typedef struct {
      string      tag;
      logic       start;
      logic [3:0] len;
      logic       en;
      logic       abort;
      logic [3:0] count;
      logic       busy;
      logic       last;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string tag, input logic s, input logic [3:0] l,
                               input logic e, input logic a, input logic [3:0] c,
                               input logic b, input logic la, input logic d);
      vec_t v;
      v.tag = tag; v.start = s; v.len = l; v.en = e; v.abort = a;
      v.count = c; v.busy = b; v.last = la; v.done = d;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] ac, input logic ab,
                        input logic al, input logic ad, input logic [3:0] ec,
                        input logic eb, input logic el, input logic ed);
      n_vec++;
      if ({ac, ab, al, ad} !== {ec, eb, el, ed}) begin
         n_err++;
         $display("FAIL %s: got count=%0d busy=%b last=%b done=%b, want count=%0d busy=%b last=%b done=%b",
                  name, ac, ab, al, ad, ec, eb, el, ed);
      end
   endtask

   task automatic build_table();
      vecs.push_back(mk("idle_ignore",  0, 0, 1, 1,  0, 0, 0, 0));
      // len=3 with en held high
      vecs.push_back(mk("l3_start",     1, 3, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk("l3_step1",     0, 0, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk("l3_last",      0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk("l3_done",      0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("l3_idle",      0, 0, 1, 0,  0, 0, 0, 0));
      // len=0 selects DEF_LEN=8
      vecs.push_back(mk("def_start",    1, 0, 1, 0,  7, 1, 0, 0));
      for (int c = 6; c >= 0; c--)
         vecs.push_back(mk("def_run",   0, 0, 1, 0,  4'(c), 1, (c == 0), 0));
      vecs.push_back(mk("def_done",     0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("def_idle",     0, 0, 0, 0,  0, 0, 0, 0));
      // len=2 with stalls
      vecs.push_back(mk("l2_start",     1, 2, 0, 0,  1, 1, 0, 0));
      vecs.push_back(mk("l2_hold1",     0, 0, 0, 0,  1, 1, 0, 0));
      vecs.push_back(mk("l2_en1",       0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk("l2_hold0a",    0, 0, 0, 0,  0, 1, 1, 0));
      vecs.push_back(mk("l2_hold0b",    0, 0, 0, 0,  0, 1, 1, 0));
      vecs.push_back(mk("l2_done",      0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("done_abort",   0, 0, 0, 1,  0, 0, 0, 0));
      // len=5 aborted at count=2
      vecs.push_back(mk("l5_start",     1, 5, 1, 0,  4, 1, 0, 0));
      vecs.push_back(mk("l5_step1",     0, 0, 1, 0,  3, 1, 0, 0));
      vecs.push_back(mk("l5_step2",     0, 0, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk("l5_abort",     0, 0, 1, 1,  0, 0, 0, 0));
      vecs.push_back(mk("l5_no_done",   0, 0, 1, 0,  0, 0, 0, 0));
      // start+abort together in IDLE still starts
      vecs.push_back(mk("idle_st_ab",   1, 1, 0, 1,  0, 1, 1, 0));
      vecs.push_back(mk("l1_done",      0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("l1_idle",      0, 0, 1, 0,  0, 0, 0, 0));
      // back-to-back runs, start ignored during RUN
      vecs.push_back(mk("b2b_start",    1, 3, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk("b2b_step1",    0, 0, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk("b2b_last",     0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk("b2b_done",     0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("b2b_reload",   1, 4, 1, 0,  3, 1, 0, 0));
      vecs.push_back(mk("run_start_ig", 1, 9, 1, 0,  2, 1, 0, 0));
      vecs.push_back(mk("b2b2_step",    0, 0, 1, 0,  1, 1, 0, 0));
      vecs.push_back(mk("b2b2_last",    0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk("b2b2_done",    0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk("b2b2_idle",    0, 0, 0, 0,  0, 0, 0, 0));
      // maximum explicit length
      vecs.push_back(mk("l15_start",    1, 15, 0, 0, 14, 1, 0, 0));
      vecs.push_back(mk("l15_step",     0, 0, 1, 0,  13, 1, 0, 0));
      vecs.push_back(mk("l15_abort",    0, 0, 0, 1,  0, 0, 0, 0));
   endtask

   initial begin
      reset = 1'b1;
      start = 0; len = 0; en = 0; abort = 0;
      start16 = 0; len16 = 0; en16 = 0; abort16 = 0;
      build_table();

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", count, busy, last, done, 0, 0, 0, 0);
      reset = 1'b0;

      // Start a run, then assert reset mid-cycle and check outputs clear without a clock edge.
      start = 1; len = 5; en = 1;
      @(posedge clk); #1;
      check("pre_reset_run", count, busy, last, done, 4, 1, 0, 0);
      start = 0;
      #2 reset = 1'b1;
      #1;
      check("async_reset", count, busy, last, done, 0, 0, 0, 0);
      en = 0;
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (vecs[i]) begin
         start = vecs[i].start; len = vecs[i].len; en = vecs[i].en; abort = vecs[i].abort;
         @(posedge clk); #1;
         check(vecs[i].tag, count, busy, last, done,
               vecs[i].count, vecs[i].busy, vecs[i].last, vecs[i].done);
      end
      start = 0; len = 0; en = 0; abort = 0;

      // DEF_LEN = 2^W: loads all-ones and runs 16 steps without wrapping.
      start16 = 1; len16 = 0; en16 = 1;
      @(posedge clk); #1;
      check("def16_start", count16, busy16, last16, done16, 15, 1, 0, 0);
      start16 = 0;
      for (int c = 14; c >= 0; c--) begin
         @(posedge clk); #1;
         check("def16_run", count16, busy16, last16, done16, 4'(c), 1, (c == 0), 0);
      end
      @(posedge clk); #1;
      check("def16_done", count16, busy16, last16, done16, 0, 0, 0, 1);
      en16 = 0;
      @(posedge clk); #1;
      check("def16_idle", count16, busy16, last16, done16, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
